uart_cfg: RTL and testbench
===========================

UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 Parameter FREQ_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 38400, line bit rate; oversample divisor DIV = FREQ_HZ/BAUD/16, clamped to a minimum of 1.
REQ-003 Parameter DATA_BITS, default 8, legal range 5..8, data bits per frame.
REQ-004 Parameter PARITY, default 0, 0=none, 1=even, 2=odd.
REQ-005 Parameter STOP_BITS, default 1, legal values 1 or 2, stop bits transmitted.
REQ-006 Port list, one per line: name, direction, width, meaning.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- uart_rxd  in  1  serial receive line, asynchronous to clk.
- uart_txd  out  1  serial transmit line, idles high.
- led_rx  out  1  high while the receiver is inside a frame.
- led_tx  out  1  high while tx_busy is high.
- rx_data  out  8  received byte, LSB-aligned; bits above DATA_BITS read 0.
- rx_avail  out  1  rx_data is valid.
- rx_error  out  1  framing error: stop bit sampled low.
- rx_parity_err  out  1  parity mismatch.
- rx_overrun  out  1  frame lost because no storage was free.
- rx_ack  in  1  consumer acknowledge; clears flags or pops data.
- tx_data  in  8  byte to send; only the low DATA_BITS bits are used.
- tx_wr  in  1  write strobe.
- tx_busy  out  1  transmitter occupied.

Function
REQ-007 The tick counter shall count DIV-1 down to 0 and reload; tick is asserted for one clk cycle at 0.
REQ-008 uart_rxd shall pass through a 2-flop synchroniser; both flops reset to 1.
REQ-009 The RX FSM shall have states IDLE, START, DATA, PARITY and STOP; on a tick, IDLE moves to START when the synchronised rxd is 0.
REQ-010 START shall sample 8 ticks after detection (mid-bit); a high sample is a false start and the FSM returns to IDLE with no flag set.
REQ-011 DATA shall sample every 16 ticks, DATA_BITS times, LSB first.
REQ-012 PARITY shall be visited only when PARITY!=0; it samples one bit and compares it against the even or odd parity of the data bits.
REQ-013 STOP shall sample one bit; the receiver checks only the first stop bit regardless of STOP_BITS, then returns to IDLE.
REQ-014 Good frame: the data byte is stored and rx_avail=1. Stop sampled low: rx_error=1 and no data is stored. Parity mismatch with a good stop bit: rx_parity_err=1 and no data is stored.
REQ-015 rx_ack shall clear rx_error, rx_parity_err and rx_overrun; if rx_ack coincides with a new flag event, the new event wins.
REQ-016 led_rx shall be 1 from START entry until the FSM returns to IDLE.
REQ-017 The TX FSM shall have states IDLE, START, DATA, PARITY and STOP; each bit lasts exactly 16 ticks.
REQ-018 tx_wr while tx_busy=0 shall latch tx_data and set tx_busy=1 on the next clk edge.
REQ-019 tx_wr while tx_busy=1 shall be ignored.
REQ-020 The start bit (0) shall begin on the first tick after the latch, followed by data LSB first, then the parity bit if enabled, then STOP_BITS high bits.
REQ-021 tx_busy shall fall in the cycle the final stop bit completes 16 ticks; a tx_wr in that same cycle is ignored.

Reset
REQ-022 While reset=0: uart_txd=1, tx_busy=0, led_tx=0, led_rx=0, rx_data=0, rx_avail=0, rx_error=0, rx_parity_err=0, rx_overrun=0, both FSMs in IDLE, tick counter=DIV-1.
REQ-023 Reset asserted mid-frame shall abort both frames immediately; no partial byte is delivered after release.

Configuration
REQ-024 Macro UART_CFG_RX_FIFO_EN defined: received bytes enter a 4-entry FIFO; rx_data shows the head entry; rx_avail means the FIFO is not empty; rx_ack pops one entry; a frame arriving while the FIFO is full is dropped and sets rx_overrun.
REQ-025 Simultaneous push and pop on a full FIFO shall succeed with no overrun.
REQ-026 Macro undefined: a single holding register is used; rx_ack clears rx_avail; a good frame arriving while rx_avail=1 is dropped, rx_data is unchanged and rx_overrun=1.

Verification
REQ-027 DIV=4, defaults, tx_wr with 0xA5 -> uart_txd shows 0,1,0,1,0,0,1,0,1,1, each bit 64 clk long; tx_busy=1 for 640 clk.
REQ-028 PARITY=1, DATA_BITS=7, rx frame 0x55 with parity 0 -> rx_data=0x55 and rx_avail=1; the same frame with parity 1 -> rx_parity_err=1 and rx_avail=0.
REQ-029 An 0x3C frame with its stop bit low -> rx_error=1, rx_avail=0; rx_ack -> rx_error=0.
REQ-030 A 3-tick low glitch on uart_rxd -> no flag asserted; the FSM is back in IDLE by 9 ticks after the glitch.
REQ-031 FIFO enabled, 5 frames 0x01..0x05 with no rx_ack -> 0x01..0x04 read back in order and rx_overrun=1; FIFO disabled, 2 frames -> rx_data=0x01 and rx_overrun=1.
REQ-032 reset asserted for 1 cycle at data bit 3 of a tx frame -> uart_txd=1 and tx_busy=0 immediately; no rx_avail afterwards.

Source files
------------

// File: rtl/uart_cfg.sv
// uart_cfg: UART with 16x oversampled receiver, transmitter and receive storage.
// Define UART_CFG_RX_FIFO_EN for a 4-entry receive FIFO; otherwise a single holding register.
module uart_cfg #(
   parameter int unsigned FREQ_HZ   = 100000000,
   parameter int unsigned BAUD      = 38400,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rxd,
   output logic       uart_txd,
   output logic       led_rx,
   output logic       led_tx,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   output logic       rx_error,
   output logic       rx_parity_err,
   output logic       rx_overrun,
   input  logic       rx_ack,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_busy
);
   localparam int unsigned DIV_RAW = FREQ_HZ / BAUD / 16;
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [CW-1:0] tick_cnt;
   logic          tick;
   logic          rxd_meta, rxd_s;

   assign tick = (tick_cnt == '0);

   always_ff @(posedge clk or negedge reset)
      if (!reset)    tick_cnt <= DIV_M1;
      else if (tick) tick_cnt <= DIV_M1;
      else           tick_cnt <= tick_cnt - 1'b1;

   always_ff @(posedge clk or negedge reset)
      if (!reset) {rxd_meta, rxd_s} <= 2'b11;
      else        {rxd_meta, rxd_s} <= {uart_rxd, rxd_meta};

   // Receiver
   state_t     rx_state, rx_state_nx;
   logic [3:0] rx_cnt, rx_cnt_nx;
   logic [2:0] rx_idx, rx_idx_nx;
   logic [7:0] rx_shift, rx_shift_nx;
   logic       rx_perr, rx_perr_nx;
   logic       rx_par_exp, ev_good, ev_ferr, ev_perr, ev_ovr;

   assign rx_par_exp = (PARITY == 1) ? ^rx_shift : ~^rx_shift;
   assign led_rx     = (rx_state != S_IDLE);

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_shift <= '0;
         rx_perr  <= 1'b0;
      end else begin
         rx_state <= rx_state_nx;
         rx_cnt   <= rx_cnt_nx;
         rx_idx   <= rx_idx_nx;
         rx_shift <= rx_shift_nx;
         rx_perr  <= rx_perr_nx;
      end

   // Counter wraps 15->0 naturally, so each bit boundary falls on the 16th tick.
   always_comb begin
      rx_state_nx = rx_state;
      rx_cnt_nx   = rx_cnt;
      rx_idx_nx   = rx_idx;
      rx_shift_nx = rx_shift;
      rx_perr_nx  = rx_perr;
      ev_good     = 1'b0;
      ev_ferr     = 1'b0;
      ev_perr     = 1'b0;
      if (tick) begin
         rx_cnt_nx = rx_cnt + 4'd1;
         case (rx_state)
            S_IDLE: begin
               rx_cnt_nx = '0;
               if (!rxd_s) begin
                  rx_state_nx = S_START;
                  rx_idx_nx   = '0;
                  rx_shift_nx = '0;
                  rx_perr_nx  = 1'b0;
               end
            end
            S_START:
               if (rx_cnt == 4'd7) begin
                  rx_cnt_nx   = '0;
                  rx_state_nx = rxd_s ? S_IDLE : S_DATA;
               end
            S_DATA:
               if (rx_cnt == 4'd15) begin
                  rx_shift_nx[rx_idx] = rxd_s;
                  rx_idx_nx           = rx_idx + 3'd1;
                  if (rx_idx == LAST_BIT) rx_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
               end
            S_PARITY:
               if (rx_cnt == 4'd15) begin
                  rx_perr_nx  = (rxd_s != rx_par_exp);
                  rx_state_nx = S_STOP;
               end
            S_STOP:
               if (rx_cnt == 4'd15) begin
                  rx_state_nx = S_IDLE;
                  if (!rxd_s)       ev_ferr = 1'b1;
                  else if (rx_perr) ev_perr = 1'b1;
                  else              ev_good = 1'b1;
               end
            default: rx_state_nx = S_IDLE;
         endcase
      end
   end

`ifdef UART_CFG_RX_FIFO_EN
   logic [7:0] fifo [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   logic       push, pop;

   assign pop      = rx_ack && (count != 3'd0);
   assign push     = ev_good && ((count != 3'd4) || pop);
   assign ev_ovr   = ev_good && !push;
   assign rx_avail = (count != 3'd0);
   assign rx_data  = rx_avail ? fifo[rd_ptr] : '0;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         fifo   <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= rx_shift;
            wr_ptr       <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b00, push} - {2'b00, pop};
      end
`else
   assign ev_ovr = ev_good && rx_avail && !rx_ack;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rx_data  <= '0;
         rx_avail <= 1'b0;
      end else if (ev_good && !ev_ovr) begin
         rx_data  <= rx_shift;
         rx_avail <= 1'b1;
      end else if (rx_ack) begin
         rx_avail <= 1'b0;
      end
`endif

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rx_error      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         if (ev_ferr) rx_error <= 1'b1;      else if (rx_ack) rx_error <= 1'b0;
         if (ev_perr) rx_parity_err <= 1'b1; else if (rx_ack) rx_parity_err <= 1'b0;
         if (ev_ovr)  rx_overrun <= 1'b1;    else if (rx_ack) rx_overrun <= 1'b0;
      end

   // Transmitter
   state_t     tx_state, tx_state_nx;
   logic [3:0] tx_cnt, tx_cnt_nx;
   logic [2:0] tx_idx, tx_idx_nx;
   logic [7:0] tx_shift, tx_shift_nx;
   logic       tx_armed, tx_armed_nx, txd_q, txd_nx, tx_par;

   assign tx_par   = (PARITY == 1) ? ^tx_shift : ~^tx_shift;
   assign tx_busy  = (tx_state != S_IDLE);
   assign led_tx   = tx_busy;
   assign uart_txd = txd_q;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         tx_armed <= 1'b0;
         txd_q    <= 1'b1;
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         tx_idx   <= tx_idx_nx;
         tx_shift <= tx_shift_nx;
         tx_armed <= tx_armed_nx;
         txd_q    <= txd_nx;
      end

   // START holds the line high until the first tick after the latch (tx_armed).
   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt;
      tx_idx_nx   = tx_idx;
      tx_shift_nx = tx_shift;
      tx_armed_nx = tx_armed;
      txd_nx      = txd_q;
      if (tx_state == S_IDLE) begin
         if (tx_wr) begin
            tx_shift_nx = tx_data & DATA_MASK;
            tx_armed_nx = 1'b0;
            tx_cnt_nx   = '0;
            tx_state_nx = S_START;
         end
      end else if (tick) begin
         tx_cnt_nx = tx_cnt + 4'd1;
         case (tx_state)
            S_START:
               if (!tx_armed) begin
                  tx_armed_nx = 1'b1;
                  tx_cnt_nx   = '0;
                  txd_nx      = 1'b0;
               end else if (tx_cnt == 4'd15) begin
                  tx_state_nx = S_DATA;
                  tx_idx_nx   = '0;
                  txd_nx      = tx_shift[0];
               end
            S_DATA:
               if (tx_cnt == 4'd15) begin
                  if (tx_idx != LAST_BIT) begin
                     tx_idx_nx = tx_idx + 3'd1;
                     txd_nx    = tx_shift[tx_idx + 3'd1];
                  end else if (PARITY != 0) begin
                     tx_state_nx = S_PARITY;
                     txd_nx      = tx_par;
                  end else begin
                     tx_state_nx = S_STOP;
                     tx_idx_nx   = '0;
                     txd_nx      = 1'b1;
                  end
               end
            S_PARITY:
               if (tx_cnt == 4'd15) begin
                  tx_state_nx = S_STOP;
                  tx_idx_nx   = '0;
                  txd_nx      = 1'b1;
               end
            S_STOP:
               if (tx_cnt == 4'd15) begin
                  if (tx_idx == STOP_LAST) tx_state_nx = S_IDLE;
                  else                     tx_idx_nx   = tx_idx + 3'd1;
               end
            default: begin
               tx_state_nx = S_IDLE;
               txd_nx      = 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_cfg.sv
// Scoreboard bench for uart_cfg: an 8N1 instance (with TX->RX loopback) and a 7E2 instance, DIV=4.
module tb_uart_cfg;
   localparam int unsigned FREQ = 2457600;
   localparam int unsigned BAUD = 38400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, line0, line1, loop0, rxd0;
   logic       txd0, led_rx0, led_tx0, avail0, err0, perr0, ovr0, ack0, wr0, busy0;
   logic       txd1, led_rx1, led_tx1, avail1, err1, perr1, ovr1, ack1, wr1, busy1;
   logic [7:0] rx_data0, rx_data1, tx_data0, tx_data1;

   assign rxd0 = loop0 ? txd0 : line0;

   uart_cfg #(.FREQ_HZ(FREQ), .BAUD(BAUD)) dut0 (
      .clk(clk), .reset(rst_n), .uart_rxd(rxd0), .uart_txd(txd0), .led_rx(led_rx0), .led_tx(led_tx0),
      .rx_data(rx_data0), .rx_avail(avail0), .rx_error(err0), .rx_parity_err(perr0), .rx_overrun(ovr0),
      .rx_ack(ack0), .tx_data(tx_data0), .tx_wr(wr0), .tx_busy(busy0));

   uart_cfg #(.FREQ_HZ(FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut1 (
      .clk(clk), .reset(rst_n), .uart_rxd(line1), .uart_txd(txd1), .led_rx(led_rx1), .led_tx(led_tx1),
      .rx_data(rx_data1), .rx_avail(avail1), .rx_error(err1), .rx_parity_err(perr1), .rx_overrun(ovr1),
      .rx_ack(ack1), .tx_data(tx_data1), .tx_wr(wr1), .tx_busy(busy1));

   int         n_checks = 0;
   int         n_bad = 0;
   logic [7:0] exp_rx [$];
   bit         exp_bits [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic get_txd(input int sel);  return sel ? txd1 : txd0;  endfunction
   function automatic logic get_busy(input int sel); return sel ? busy1 : busy0; endfunction
   function automatic logic get_avail(input int sel); return sel ? avail1 : avail0; endfunction
   function automatic logic [7:0] get_data(input int sel); return sel ? rx_data1 : rx_data0; endfunction

   task automatic set_tx(input int sel, input logic [7:0] d, input logic w);
      if (sel == 0) begin tx_data0 = d; wr0 = w; end
      else          begin tx_data1 = d; wr1 = w; end
   endtask

   task automatic pulse_ack(input int sel);
      @(negedge clk);
      if (sel == 0) ack0 = 1'b1; else ack1 = 1'b1;
      @(negedge clk);
      ack0 = 1'b0; ack1 = 1'b0;
   endtask

   // Serial frame on a receive line, one bit per 64 clk; par<0 means no parity bit.
   task automatic send_frame(input int sel, input logic [7:0] data, input int nbits, input int par, input logic stop);
      bit q[$];
      q.push_back(1'b0);
      for (int i = 0; i < nbits; i++) q.push_back(data[i]);
      if (par >= 0) q.push_back(par[0]);
      q.push_back(stop);
      foreach (q[i]) begin
         if (sel == 0) line0 = q[i]; else line1 = q[i];
         repeat (64) @(negedge clk);
      end
      if (sel == 0) line0 = 1'b1; else line1 = 1'b1;
      repeat (64) @(negedge clk);
   endtask

   task automatic expect_rx(input int sel);
      logic [7:0] e;
      int         k;
      e = exp_rx.pop_front();
      k = 0;
      while (get_avail(sel) !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
      check_eq("rx_avail", get_avail(sel), 1);
      check_eq("rx_data", get_data(sel), e);
      pulse_ack(sel);
   endtask

   // Also pokes tx_wr mid-frame and in the final cycle; both writes must be ignored.
   task automatic tx_send(input int sel, input logic [7:0] data, input int dbits, input int par, input int nstop);
      int   k, nb;
      logic d;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < dbits; i++) exp_bits.push_back(data[i]);
      if (par >= 0) exp_bits.push_back(par[0]);
      for (int i = 0; i < nstop; i++) exp_bits.push_back(1'b1);
      nb = exp_bits.size();
      @(negedge clk); set_tx(sel, data, 1'b1);
      @(negedge clk); set_tx(sel, data, 1'b0);
      check_eq("busy_after_wr", get_busy(sel), 1);
      k = 0;
      while (get_txd(sel) !== 1'b0 && k < 20) begin @(negedge clk); k++; end
      check_eq("start_bit_seen", get_txd(sel), 0);
      k = 0;
      while (get_busy(sel) === 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
         set_tx(sel, 8'hFF, (k == 100) || (k == nb * 64 - 1));
         if (k % 64 == 32 && exp_bits.size() > 0) begin
            d = exp_bits.pop_front();
            check_eq("txd_bit", get_txd(sel), d);
         end
      end
      set_tx(sel, 8'h00, 1'b0);
      check_eq("tx_frame_len", k, nb * 64);
      repeat (3) @(negedge clk);
      check_eq("wr_at_end_ignored", get_busy(sel), 0);
      check_eq("txd_idle", get_txd(sel), 1);
   endtask

   initial begin
      int k;
      rst_n = 1'b0; line0 = 1'b1; line1 = 1'b1; loop0 = 1'b0;
      ack0 = 1'b0; ack1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0; tx_data0 = '0; tx_data1 = '0;
      repeat (5) @(negedge clk);
      check_eq("rst_txd", txd0, 1);
      check_eq("rst_busy", busy0, 0);
      check_eq("rst_leds", {led_tx0, led_rx0}, 0);
      check_eq("rst_rx_data", rx_data0, 0);
      check_eq("rst_flags", {avail0, err0, perr0, ovr0}, 0);
      check_eq("rst_flags1", {avail1, err1, perr1, ovr1, busy1}, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // 8N1 transmit of 0xA5 looped back into the receiver
      loop0 = 1'b1;
      exp_rx.push_back(8'hA5);
      tx_send(0, 8'hA5, 8, -1, 1);
      expect_rx(0);
      check_eq("avail_after_ack", avail0, 0);
      loop0 = 1'b0;

      // 7E2 transmit: top bit of tx_data must be dropped
      tx_send(1, 8'hD5, 7, 0, 2);

      // 7E1 receive: good parity, then bad parity
      exp_rx.push_back(8'h55);
      send_frame(1, 8'h55, 7, 0, 1'b1);
      check_eq("par_ok_flag", perr1, 0);
      expect_rx(1);
      send_frame(1, 8'h55, 7, 1, 1'b1);
      check_eq("par_err_flag", perr1, 1);
      check_eq("par_err_no_data", avail1, 0);
      pulse_ack(1);
      check_eq("par_err_cleared", perr1, 0);

      // Framing error
      send_frame(0, 8'h3C, 8, -1, 1'b0);
      repeat (128) @(negedge clk);
      check_eq("frame_err_flag", err0, 1);
      check_eq("frame_err_no_data", avail0, 0);
      pulse_ack(0);
      check_eq("frame_err_cleared", err0, 0);

      // 3-tick glitch is a false start
      line0 = 1'b0;
      repeat (12) @(negedge clk);
      line0 = 1'b1;
      repeat (8) @(negedge clk);
      check_eq("glitch_led_rx_on", led_rx0, 1);
      repeat (28) @(negedge clk);
      check_eq("glitch_back_idle", led_rx0, 0);
      check_eq("glitch_no_flags", {avail0, err0, perr0, ovr0}, 0);
      repeat (64) @(negedge clk);

      // Overrun
`ifdef UART_CFG_RX_FIFO_EN
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) exp_rx.push_back(8'(i));
         send_frame(0, 8'(i), 8, -1, 1'b1);
      end
      check_eq("overrun_flag", ovr0, 1);
      for (int i = 0; i < 4; i++) expect_rx(0);
`else
      exp_rx.push_back(8'h01);
      send_frame(0, 8'h01, 8, -1, 1'b1);
      send_frame(0, 8'h02, 8, -1, 1'b1);
      check_eq("overrun_flag", ovr0, 1);
      expect_rx(0);
`endif
      check_eq("overrun_cleared", ovr0, 0);
      check_eq("drained", avail0, 0);

      // Reset in the middle of data bit 3 of a looped-back frame
      loop0 = 1'b1;
      @(negedge clk); set_tx(0, 8'hA5, 1'b1);
      @(negedge clk); set_tx(0, 8'h00, 1'b0);
      k = 0;
      while (txd0 !== 1'b0 && k < 20) begin @(negedge clk); k++; end
      repeat (4 * 64 + 32) @(negedge clk);
      check_eq("pre_rst_txd", txd0, 0);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_txd", txd0, 1);
      check_eq("mid_rst_busy", {busy0, led_tx0, led_rx0}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12 * 64) @(negedge clk);
      check_eq("post_rst_no_avail", avail0, 0);
      check_eq("post_rst_idle", {busy0, led_rx0, err0, txd0}, 1);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
